pulse_to_level: RTL and testbench
=================================

# pulse_to_level

- Converts one-cycle pulses, such as those from the edge-to-pulse generator, back into signal levels.
- Three independent level outputs:
  - a toggle level that flips on every pulse (the pulse-to-toggle half of a pulse/toggle pair);
  - a stretched level held high for a fixed number of cycles;
  - a latched level held until acknowledged.
- Sits on the consuming side of event signalling: CDC toggle encoding, minimum-width strobes for slow logic, sticky event flags for software/FSM polling.
- The pulse input is synchronous to `clock`. Every output is registered.

## Interface

Parameters:
- STRETCH_LENGTH, 4: cycles `level_stretched_out` stays high per accepted pulse; legal range 1 to 65535.
- RETRIGGER, 1: 1 = pulse during stretch restarts the count; 0 = pulse during stretch ignored.
- TOGGLE_INITIAL, 1'b0: reset value of `level_toggle_out`.

Ports:
- clock, input, 1: single clock; all state updates on rising edge.
- clear, input, 1: reset, synchronous and active-high; overrides all other inputs.
- pulse_in, input, 1: event pulse; each cycle high counts as one pulse.
- ack_in, input, 1: clears `level_latched_out`.
- level_toggle_out, output, 1: inverts once per pulse.
- level_stretched_out, output, 1: high for STRETCH_LENGTH cycles after an accepted pulse.
- level_latched_out, output, 1: set by pulse, cleared by ack.
- pulse_ignored_out, output, 1: one-cycle flag, high when RETRIGGER=0 and a pulse arrives during a stretch.

## Operation

- Reset values after `clear`:
  - `level_toggle_out` = TOGGLE_INITIAL;
  - all other outputs 0;
  - stretch counter 0;
  - state IDLE.
- Toggle: on each cycle with `pulse_in`=1, next `level_toggle_out` = current value inverted.
- Stretch counter: width clog2(STRETCH_LENGTH+1). Two-state FSM:
  - IDLE (counter 0, `level_stretched_out` 0): `pulse_in` loads counter with STRETCH_LENGTH and moves to STRETCH.
  - STRETCH (`level_stretched_out` 1):
    - Without an accepted pulse, the counter decrements each cycle.
    - The transition that takes the counter to 0 returns to IDLE.
    - RETRIGGER=1: `pulse_in` reloads STRETCH_LENGTH and stays in STRETCH.
    - RETRIGGER=0: `pulse_in` is not accepted; counter keeps decrementing and `pulse_ignored_out` is 1 next cycle.
  - `level_stretched_out` is 1 exactly when the registered counter is nonzero.
  - Counter never wraps: no decrement below 0; a reload always writes STRETCH_LENGTH.
- Latch:
  - `pulse_in`=1 sets it; `ack_in`=1 clears it.
  - Both in the same cycle: set wins, so the event is not lost.
  - Ack while already clear: no effect.
- `pulse_ignored_out` is never 1 when RETRIGGER=1.
- `clear` in the same cycle as `pulse_in`: the pulse is discarded.

## Timing

- Latency: a pulse sampled in cycle N is visible on outputs in cycle N+1.
- Stretched output:
  - Isolated pulse at N: high in cycles N+1 through N+STRETCH_LENGTH, low at N+STRETCH_LENGTH+1.
  - Retrigger at M while high: high through M+STRETCH_LENGTH; no low gap.
  - RETRIGGER=0 with `pulse_in` held high: repeating pattern of STRETCH_LENGTH cycles high, 1 cycle low. The first cycle of that low gap is IDLE, so the held pulse is accepted there.
  - STRETCH_LENGTH=1: one-cycle output pulse delayed by one cycle. Back-to-back pulses with RETRIGGER=1 give a continuous high.
- Toggle:
  - `pulse_in` held high for K cycles gives K inversions, one per cycle.
  - A downstream edge detector recovers each pulse one cycle late.
- `clear` mid-stretch: all outputs at reset values in the next cycle.
- `ack_in` at cycle N: latched output low at N+1, unless `pulse_in` is also 1 at N.
- No combinational path from any input to any output.

## Test plan

- Reset and single pulse:
  - Stimulus: `clear` for 2 cycles, then `pulse_in` at cycle 5 with STRETCH_LENGTH=4, TOGGLE_INITIAL=0.
  - Before the pulse, all outputs hold their reset values.
  - At cycle 6: toggle=1, latched=1.
  - Stretched high in cycles 6–9, low at 10.
- Retrigger:
  - Stimulus: RETRIGGER=1, STRETCH_LENGTH=4, pulses at cycles 5 and 7.
  - Stretched high in cycles 6–11, low at 12; toggle returns to 0 at cycle 8.
  - `pulse_ignored_out` stays 0.
- No retrigger:
  - Stimulus: RETRIGGER=0, STRETCH_LENGTH=4, pulses at cycles 5 and 7.
  - Stretched high in cycles 6–9 only.
  - `pulse_ignored_out`=1 at cycle 8 only.
  - Toggle still inverts at cycles 6 and 8.
- Held input:
  - Stimulus: RETRIGGER=0, STRETCH_LENGTH=2, `pulse_in` high for cycles 5–12.
  - Stretched pattern from cycle 6: 1,1,0,1,1,0,1,1.
  - Toggle inverts every cycle from 6 to 13.
- Latch arbitration:
  - Stimulus: pulse at 5, `ack_in` at 8, then pulse and ack together at 10.
  - Latched high cycles 6–8, low at 9, high at 11.
- Clear mid-operation:
  - Stimulus: pulse at 5 with STRETCH_LENGTH=8, then `clear` together with `pulse_in` at cycle 7.
  - At cycle 8: all outputs at reset values.
  - Stretched output stays low afterward until the next pulse.

Source files
------------

// File: rtl/pulse_to_level_if.sv
// pulse_to_level_if
//   Groups the event input, acknowledge and the three level outputs of
//   pulse_to_level so the converter can be wired as one bundle.
//   master : event producer / consumer of the levels (drives pulse_in, ack_in)
//   slave  : the pulse_to_level block itself (drives the level outputs)
interface pulse_to_level_if;
  logic pulse_in;
  logic ack_in;
  logic level_toggle_out;
  logic level_stretched_out;
  logic level_latched_out;
  logic pulse_ignored_out;

  modport master (
    output pulse_in,
    output ack_in,
    input  level_toggle_out,
    input  level_stretched_out,
    input  level_latched_out,
    input  pulse_ignored_out
  );

  modport slave (
    input  pulse_in,
    input  ack_in,
    output level_toggle_out,
    output level_stretched_out,
    output level_latched_out,
    output pulse_ignored_out
  );
endinterface

// File: rtl/pulse_to_level.sv
// pulse_to_level
//   Turns one-cycle event pulses back into levels:
//     - a toggle level that inverts once per pulse,
//     - a stretched level held high for STRETCH_LENGTH cycles per accepted pulse,
//     - a sticky latched level held until acknowledged.
//   All outputs are registered; a pulse sampled in cycle N shows in cycle N+1.
//
// Ports
//   clock : rising-edge clock
//   clear : synchronous active-high reset, overrides every other input
//   bus   : pulse_to_level_if.slave
//             pulse_in            event pulse, each high cycle is one pulse
//             ack_in              clears level_latched_out
//             level_toggle_out    inverts on every pulse
//             level_stretched_out high for STRETCH_LENGTH cycles after an accepted pulse
//             level_latched_out   set by pulse, cleared by ack (set wins)
//             pulse_ignored_out   one-cycle flag for a pulse dropped during a stretch
//                                 (only possible with RETRIGGER = 0)
//
// Parameters
//   STRETCH_LENGTH : 1..65535 cycles of stretched output per accepted pulse
//   RETRIGGER      : 1 = pulse during stretch reloads the count, 0 = ignored
//   TOGGLE_INITIAL : reset value of level_toggle_out
module pulse_to_level #(
  parameter int unsigned STRETCH_LENGTH = 4,
  parameter logic        RETRIGGER      = 1'b1,
  parameter logic        TOGGLE_INITIAL = 1'b0
) (
  input  logic                   clock,
  input  logic                   clear,
  pulse_to_level_if.slave        bus
);

  localparam int unsigned     CW   = $clog2(STRETCH_LENGTH + 1);
  localparam logic [CW-1:0]   LOAD = CW'(STRETCH_LENGTH);
  localparam logic [CW-1:0]   ONE  = CW'(1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] STRETCH = 1'b1;

  logic [0:0]    state_q;
  logic [0:0]    state_d;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ignored_d;

  logic toggle_q;
  logic stretched_q;
  logic latched_q;
  logic ignored_q;

  // Stretch FSM next-state. The counter saturates at zero and a reload
  // always writes the full STRETCH_LENGTH.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ignored_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pulse_in) begin
          count_d = LOAD;
          state_d = STRETCH;
        end
      end
      STRETCH: begin
        if (bus.pulse_in && RETRIGGER) begin
          count_d = LOAD;
        end else begin
          if (count_q != '0) begin
            count_d = count_q - ONE;
          end
          if (count_q <= ONE) begin
            state_d = IDLE;
          end
          ignored_d = bus.pulse_in && !RETRIGGER;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      count_q     <= '0;
      toggle_q    <= TOGGLE_INITIAL;
      stretched_q <= 1'b0;
      latched_q   <= 1'b0;
      ignored_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      // Registered copy of "next counter nonzero" so the output equals
      // (counter != 0) without a decode after the flops.
      stretched_q <= (count_d != '0);
      ignored_q   <= ignored_d;
      if (bus.pulse_in) begin
        toggle_q <= ~toggle_q;
      end
      // Set has priority over ack so a simultaneous event is not lost.
      if (bus.pulse_in) begin
        latched_q <= 1'b1;
      end else if (bus.ack_in) begin
        latched_q <= 1'b0;
      end
    end
  end

  assign bus.level_toggle_out    = toggle_q;
  assign bus.level_stretched_out = stretched_q;
  assign bus.level_latched_out   = latched_q;
  assign bus.pulse_ignored_out   = ignored_q;

endmodule

// File: tb/tb_pulse_to_level.sv
module tb_pulse_to_level;

  localparam int N = 5;

  function automatic int sl_of(input int i);
    case (i)
      0: return 4;
      1: return 4;
      2: return 2;
      3: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic int rt_of(input int i);
    case (i)
      1, 2: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int ti_of(input int i);
    case (i)
      2, 4: return 1;
      default: return 0;
    endcase
  endfunction

  logic clk = 1'b0;
  logic pulse = 1'b0;
  logic ack = 1'b0;
  logic clear = 1'b1;

  always #5 clk = ~clk;

  logic [N-1:0] dut_tog, dut_str, dut_lat, dut_ign;
  logic [N-1:0] exp_tog, exp_str, exp_lat, exp_ign, exp_valid;

  int checks = 0;
  int passes = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g
    localparam int   SL = sl_of(gi);
    localparam logic RT = (rt_of(gi) != 0);
    localparam logic TI = (ti_of(gi) != 0);

    pulse_to_level_if bus ();
    assign bus.pulse_in = pulse;
    assign bus.ack_in   = ack;

    pulse_to_level #(
      .STRETCH_LENGTH (SL),
      .RETRIGGER      (RT),
      .TOGGLE_INITIAL (TI)
    ) dut (
      .clock (clk),
      .clear (clear),
      .bus   (bus.slave)
    );

    assign dut_tog[gi] = bus.level_toggle_out;
    assign dut_str[gi] = bus.level_stretched_out;
    assign dut_lat[gi] = bus.level_latched_out;
    assign dut_ign[gi] = bus.pulse_ignored_out;

    // Reference: stretched level is "now lies within (last accepted pulse,
    // last accepted pulse + SL]"; a pulse is accepted if retriggering is
    // allowed or the level is currently low.
    longint m_now  = 0;
    longint m_last = -1000;
    logic   m_valid = 1'b0;
    logic   e_tog, e_str, e_lat, e_ign;

    always @(posedge clk) begin : mdl
      longint nl;
      logic   sn;
      sn = (m_now >= m_last + 1) && (m_now <= m_last + SL);
      nl = m_last;
      if (clear) begin
        nl = -1000;
        e_tog   <= TI;
        e_lat   <= 1'b0;
        e_ign   <= 1'b0;
        m_valid <= 1'b1;
      end else begin
        if (pulse && (RT || !sn)) nl = m_now;
        if (pulse) e_tog <= ~e_tog;
        if (pulse) e_lat <= 1'b1;
        else if (ack) e_lat <= 1'b0;
        e_ign <= pulse && !RT && sn;
      end
      e_str  <= (m_now + 1 >= nl + 1) && (m_now + 1 <= nl + SL);
      m_last <= nl;
      m_now  <= m_now + 1;
    end

    assign exp_tog[gi]   = e_tog;
    assign exp_str[gi]   = e_str;
    assign exp_lat[gi]   = e_lat;
    assign exp_ign[gi]   = e_ign;
    assign exp_valid[gi] = m_valid;
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
  endtask

  task automatic compare_model();
    for (int i = 0; i < N; i++) begin
      if (exp_valid[i]) begin
        chk($sformatf("model_tog[%0d]", i), dut_tog[i], exp_tog[i]);
        chk($sformatf("model_str[%0d]", i), dut_str[i], exp_str[i]);
        chk($sformatf("model_lat[%0d]", i), dut_lat[i], exp_lat[i]);
        chk($sformatf("model_ign[%0d]", i), dut_ign[i], exp_ign[i]);
      end
    end
  endtask

  task automatic tick(input logic p, input logic a, input logic c);
    @(posedge clk);
    #1;
    pulse = p;
    ack   = a;
    clear = c;
    @(negedge clk);
    compare_model();
  endtask

  // Observations of one 16-cycle directed scenario, indexed [instance][cycle].
  logic [15:0] o_tog [N];
  logic [15:0] o_str [N];
  logic [15:0] o_lat [N];
  logic [15:0] o_ign [N];

  task automatic run_scn(input logic [15:0] pm, input logic [15:0] am, input logic [15:0] cm);
    for (int c = 0; c < 16; c++) begin
      tick(pm[c], am[c], cm[c]);
      for (int i = 0; i < N; i++) begin
        o_tog[i][c] = dut_tog[i];
        o_str[i][c] = dut_str[i];
        o_lat[i][c] = dut_lat[i];
        o_ign[i][c] = dut_ign[i];
      end
    end
  endtask

  task automatic chk_span(input string nm, input logic [15:0] act, input logic [15:0] exp,
                          input int lo, input int hi);
    for (int c = lo; c <= hi; c++) chk($sformatf("%s_c%0d", nm, c), act[c], exp[c]);
  endtask

  initial begin
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    // Reset and single pulse at cycle 5.
    run_scn(16'h0020, 16'h0000, 16'h0003);
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("A_rst_tog0_c%0d", c), o_tog[0][c], 1'b0);
      chk($sformatf("A_rst_lat0_c%0d", c), o_lat[0][c], 1'b0);
      chk($sformatf("A_rst_ign0_c%0d", c), o_ign[0][c], 1'b0);
    end
    chk("A_rst_tog2_c3", o_tog[2][3], 1'b1);
    chk("A_tog0_c6", o_tog[0][6], 1'b1);
    chk("A_lat0_c6", o_lat[0][6], 1'b1);
    chk_span("A_str0", o_str[0], 16'h03C0, 2, 12);
    chk_span("A_str3", o_str[3], 16'h0040, 2, 9);

    // Pulses at 5 and 7: retrigger vs no retrigger.
    run_scn(16'h00A0, 16'h0000, 16'h0003);
    chk_span("B_str0", o_str[0], 16'h0FC0, 2, 14);
    chk_span("B_ign0", o_ign[0], 16'h0000, 2, 15);
    chk("B_tog0_c7", o_tog[0][7], 1'b1);
    chk("B_tog0_c8", o_tog[0][8], 1'b0);
    chk_span("B_str1", o_str[1], 16'h03C0, 2, 14);
    chk_span("B_ign1", o_ign[1], 16'h0100, 2, 14);
    chk("B_tog1_c6", o_tog[1][6], 1'b1);
    chk("B_tog1_c8", o_tog[1][8], 1'b0);
    chk_span("B_str3", o_str[3], 16'h0140, 2, 12);

    // Pulse held high for cycles 5..12.
    run_scn(16'h1FE0, 16'h0000, 16'h0003);
    chk_span("C_str2", o_str[2], 16'h36C0, 2, 15);
    chk_span("C_tog2", o_tog[2], 16'hEABC, 2, 15);
    chk_span("C_str3", o_str[3], 16'h3FC0, 2, 15);

    // Latch arbitration: pulse 5, ack 8, pulse+ack 10.
    run_scn(16'h0420, 16'h0500, 16'h0003);
    chk_span("D_lat0", o_lat[0], 16'hF9C0, 2, 15);

    // Clear together with a pulse mid-stretch.
    run_scn(16'h00A0, 16'h0000, 16'h0083);
    chk_span("E_str4", o_str[4], 16'h00C0, 2, 15);
    chk_span("E_tog4", o_tog[4], 16'hFF3C, 2, 15);
    chk_span("E_lat4", o_lat[4], 16'h00C0, 2, 15);
    chk("E_ign4_c8", o_ign[4][8], 1'b0);

    // Randomized traffic with varying pulse density.
    for (int seg = 0; seg < 20; seg++) begin
      int pp;
      pp = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 45 : 92);
      for (int k = 0; k < 200; k++) begin
        tick($urandom_range(0, 99) < pp,
             $urandom_range(0, 99) < 20,
             $urandom_range(0, 199) == 0);
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
